// File: rtl/bus_interface_unit.sv
// Purpose : external-bus controller; sequences one core read/write at a time on the address/data/rw/lock pins.
// Latency : with i_ready high, o_rsp_valid pulses 3 + WAIT_STATES cycles after the accept edge.
// Backpressure: o_req_ready only in IDLE, and only while this CPU owns the lock or no external agent holds it.
//
// Ports:
//   clk, n_rst                 clock, asynchronous active-low reset
//   i_req/i_req_*, o_req_ready core request (rw, addr, wdata, lock) with valid/ready handshake
//   o_rsp_valid/rdata/err      one-cycle completion pulse with read data and timeout flag
//   o_addr, o_rw, o_data(_oe)  external pins (tristate is resolved above this block)
//   i_data, i_ready            external read data and device ready
//   i_ext_lock, o_lock         bus lock arbitration with an external agent
//   o_busy                     transfer in flight or lock held
module bus_interface_unit #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int WAIT_STATES   = 1,
    parameter int TIMEOUT       = 255,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     i_req,
    input  logic                     i_req_rw,
    input  logic [ADDR_WIDTH-1:0]    i_req_addr,
    input  logic [DATA_WIDTH-1:0]    i_req_wdata,
    input  logic                     i_req_lock,
    output logic                     o_req_ready,
    output logic                     o_rsp_valid,
    output logic [DATA_WIDTH-1:0]    o_rsp_rdata,
    output logic                     o_rsp_err,
    output logic [ADDR_WIDTH-1:0]    o_addr,
    output logic                     o_rw,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic                     o_data_oe,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     i_ready,
    input  logic                     i_ext_lock,
    output logic                     o_lock,
    output logic                     o_busy
);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;

    localparam logic [7:0]               WAIT_LOAD = 8'(WAIT_STATES);
    localparam logic [TIMEOUT_WIDTH-1:0] TOUT_LIM  = TIMEOUT_WIDTH'(TIMEOUT);
    localparam bit                       TOUT_EN   = (TIMEOUT != 0);

    state_t                   state;
    logic                     rw_q;
    logic                     lock_q;
    logic [7:0]               wait_cnt;
    logic [TIMEOUT_WIDTH-1:0] tout_cnt;

    logic                     accept;
    logic                     complete;
    logic [TIMEOUT_WIDTH-1:0] tout_inc;
    logic                     timeout_hit;

    // Once we own the lock, the external agent's lock request is ignored.
    assign o_req_ready = (state == IDLE) && (o_lock || !i_ext_lock);
    assign o_busy      = (state != IDLE) || o_lock;
    assign accept      = i_req && o_req_ready;

    assign complete    = (wait_cnt == 8'd0) && i_ready;
    // Saturating increment so a disabled timeout cannot wrap the counter.
    assign tout_inc    = (&tout_cnt) ? tout_cnt : tout_cnt + TIMEOUT_WIDTH'(1);
    // Completion is tested first in the FSM, so it wins over a same-cycle timeout.
    assign timeout_hit = TOUT_EN && (tout_inc == TOUT_LIM);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            rw_q        <= 1'b0;
            lock_q      <= 1'b0;
            wait_cnt    <= 8'd0;
            tout_cnt    <= '0;
            o_addr      <= '0;
            o_rw        <= 1'b0;
            o_data      <= '0;
            o_data_oe   <= 1'b0;
            o_lock      <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= '0;
        end else begin
            o_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Pins are loaded on the accept edge so they are valid throughout ADDR.
                        rw_q      <= i_req_rw;
                        lock_q    <= i_req_lock;
                        o_addr    <= i_req_addr;
                        o_rw      <= i_req_rw;
                        o_data_oe <= i_req_rw;
                        if (i_req_rw) begin
                            o_data <= i_req_wdata;
                        end
                        if (i_req_lock) begin
                            o_lock <= 1'b1;
                        end
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    wait_cnt <= WAIT_LOAD;
                    tout_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (complete) begin
                        o_rsp_rdata <= rw_q ? '0 : i_data;
                        o_rsp_err   <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_data_oe   <= 1'b0;
                        o_rw        <= 1'b0;
                        state       <= DONE;
                    end else begin
                        if (wait_cnt != 8'd0) begin
                            wait_cnt <= wait_cnt - 8'd1;
                        end
                        tout_cnt <= tout_inc;
                        if (timeout_hit) begin
                            o_rsp_rdata <= '0;
                            o_rsp_err   <= 1'b1;
                            o_rsp_valid <= 1'b1;
                            o_data_oe   <= 1'b0;
                            o_rw        <= 1'b0;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    // A failed locked transfer releases the bus rather than leaving it held.
                    if (!lock_q || o_rsp_err) begin
                        o_lock <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_interface_unit.sv
module tb_bus_interface_unit;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int WS = 1;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          i_req = 1'b0;
    logic          i_req_rw = 1'b0;
    logic [AW-1:0] i_req_addr = '0;
    logic [DW-1:0] i_req_wdata = '0;
    logic          i_req_lock = 1'b0;
    logic          o_req_ready;
    logic          o_rsp_valid;
    logic [DW-1:0] o_rsp_rdata;
    logic          o_rsp_err;
    logic [AW-1:0] o_addr;
    logic          o_rw;
    logic [DW-1:0] o_data;
    logic          o_data_oe;
    logic [DW-1:0] i_data = '0;
    logic          i_ready = 1'b0;
    logic          i_ext_lock = 1'b0;
    logic          o_lock;
    logic          o_busy;

    int checks   = 0;
    int failures = 0;
    bit lock_held = 1'b0;   // model: does this CPU own the bus lock while idle

    bus_interface_unit #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS), .TIMEOUT(TO), .TIMEOUT_WIDTH(8)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .i_req(i_req), .i_req_rw(i_req_rw), .i_req_addr(i_req_addr),
        .i_req_wdata(i_req_wdata), .i_req_lock(i_req_lock), .o_req_ready(o_req_ready),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_addr(o_addr), .o_rw(o_rw), .o_data(o_data), .o_data_oe(o_data_oe),
        .i_data(i_data), .i_ready(i_ready), .i_ext_lock(i_ext_lock),
        .o_lock(o_lock), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_addr"},  o_addr, 0);
        chk({tag, "_rw"},    o_rw, 0);
        chk({tag, "_data"},  o_data, 0);
        chk({tag, "_oe"},    o_data_oe, 0);
        chk({tag, "_lock"},  o_lock, 0);
        chk({tag, "_valid"}, o_rsp_valid, 0);
        chk({tag, "_err"},   o_rsp_err, 0);
        chk({tag, "_rdata"}, o_rsp_rdata, 0);
        chk({tag, "_busy"},  o_busy, 0);
    endtask

    // One transfer. n = number of leading WAIT cycles with i_ready low.
    // Model: the transfer completes in the first WAIT cycle k with k >= WS and
    // k >= n; if no such k < TO exists, it times out in WAIT cycle TO-1.
    // The response appears 3 + k cycles after the accept edge.
    task automatic xfer(input bit rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input bit lk, input int n, input logic [DW-1:0] ext);
        int            kc;
        int            endc;
        int            waited;
        bit            err;
        bit            lock_during;
        bit            lock_after;
        logic [DW-1:0] exp_rd;
        kc          = (n > WS) ? n : WS;
        err         = (TO != 0) && (kc > TO - 1);
        endc        = 3 + (err ? TO - 1 : kc);
        exp_rd      = (rw || err) ? '0 : ext;
        lock_during = lock_held || lk;
        lock_after  = lk && !err;

        i_req = 1'b1; i_req_rw = rw; i_req_addr = addr; i_req_wdata = wd;
        i_req_lock = lk; i_data = ext; i_ready = 1'b0;
        #1;
        waited = 0;
        while (!o_req_ready && waited < 20) begin
            step();
            waited++;
        end
        chk("accept_ready", o_req_ready, 1);
        step();                                   // cycle T+1 (ADDR)
        i_req = 1'b0; i_req_lock = 1'b0; i_req_wdata = ~wd;
        chk("addr_phase_addr", o_addr, addr);
        chk("addr_phase_rw",   o_rw, rw);
        chk("addr_phase_oe",   o_data_oe, rw);
        chk("addr_phase_lock", o_lock, lock_during);
        chk("addr_phase_busy", o_busy, 1);
        chk("addr_phase_rdy",  o_req_ready, 0);
        if (rw) chk("addr_phase_data", o_data, wd);
        for (int c = 2; c <= endc; c++) begin
            step();                               // cycle T+c
            i_ready = ((c - 2) >= n);
            if (c < endc) begin
                chk("wait_no_rsp",  o_rsp_valid, 0);
                chk("wait_addr",    o_addr, addr);
                chk("wait_rw",      o_rw, rw);
                chk("wait_oe",      o_data_oe, rw);
            end
        end
        chk("done_valid", o_rsp_valid, 1);
        chk("done_rdata", o_rsp_rdata, exp_rd);
        chk("done_err",   o_rsp_err, err);
        chk("done_oe",    o_data_oe, 0);
        chk("done_rw",    o_rw, 0);
        chk("done_addr",  o_addr, addr);
        chk("done_lock",  o_lock, lock_during);
        step();                                   // back in IDLE
        i_ready = 1'b0;
        chk("idle_valid", o_rsp_valid, 0);
        chk("idle_lock",  o_lock, lock_after);
        chk("idle_busy",  o_busy, lock_after);
        chk("idle_ready", o_req_ready, lock_after || !i_ext_lock);
        lock_held = lock_after;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("rst");
        chk("rst_ready", o_req_ready, 1);
        n_rst = 1'b1;
        step();
        chk_reset_values("post_rst");

        // Basic read and write
        xfer(1'b0, 16'h1234, 16'h0000, 1'b0, 0, 16'hBEEF);
        xfer(1'b1, 16'h00F0, 16'h5A5A, 1'b0, 0, 16'hDEAD);

        // Device stretches 5 extra cycles, then never answers
        xfer(1'b0, 16'h0A0A, 16'h0000, 1'b0, WS + 5, 16'h1357);
        xfer(1'b0, 16'h0B0B, 16'h0000, 1'b0, 100000, 16'hFFFF);

        // External lock stalls a pending request with no pin activity
        i_ext_lock = 1'b1; i_req = 1'b1; i_req_addr = 16'h7777; i_req_rw = 1'b1; i_req_wdata = 16'h1111;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("extlock_ready", o_req_ready, 0);
            chk("extlock_busy",  o_busy, 0);
            chk("extlock_oe",    o_data_oe, 0);
            chk("extlock_addr",  o_addr, 16'h0B0B);
        end
        i_ext_lock = 1'b0;
        #1;
        chk("extlock_release_ready", o_req_ready, 1);
        xfer(1'b1, 16'h7777, 16'h1111, 1'b0, 0, 16'h0000);

        // Locked read, external lock raised, unlocked write still accepted
        xfer(1'b0, 16'h4000, 16'h0000, 1'b1, 0, 16'hC0DE);
        i_ext_lock = 1'b1;
        #1;
        chk("locked_hold",  o_lock, 1);
        chk("locked_ready", o_req_ready, 1);
        xfer(1'b1, 16'h4002, 16'hA5A5, 1'b0, 2, 16'h0000);
        chk("unlocked_stall", o_req_ready, 0);
        i_ext_lock = 1'b0;

        // Reset during WAIT aborts a locked read with no response
        i_req = 1'b1; i_req_rw = 1'b0; i_req_addr = 16'h5555; i_req_lock = 1'b1; i_ready = 1'b0;
        step();
        i_req = 1'b0; i_req_lock = 1'b0;
        chk("abort_addr_lock", o_lock, 1);
        step();
        step();
        chk("abort_wait_busy", o_busy, 1);
        #2;
        n_rst = 1'b0;
        #1;
        chk_reset_values("abort");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_hold_valid", o_rsp_valid, 0);
        end
        n_rst = 1'b1;
        lock_held = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("abort_no_pulse", o_rsp_valid, 0);
        end

        // Randomised transfers against the model
        for (int i = 0; i < 24; i++) begin
            i_ext_lock = lock_held ? 1'($urandom_range(0, 1)) : 1'b0;
            xfer(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)), 16'($urandom));
        end
        i_ext_lock = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_interface_unit.md
Name: bus_interface_unit

Overview:
Parametrised external-bus controller that sits between the CPU core units (program counter, decoder, ALU) and the CPU's external address/data/rw/lock pins. It accepts one read or write request at a time from the core and sequences it on the pins through address, wait-state and completion phases. Wait states are programmable and the external device can stretch a transfer with a ready signal; a timeout bounds that stretching. Bus locking is arbitrated between this CPU and an external agent. Pin tristating is done at the top level; this block provides the data output and the output-enable control.

Parameters:
ADDR_WIDTH, 16, width of address bus
DATA_WIDTH, 16, width of data bus
WAIT_STATES, 1, minimum extra WAIT cycles per transfer (0..255)
TIMEOUT, 255, maximum WAIT cycles before error; 0 disables timeout
TIMEOUT_WIDTH, 8, width of timeout counter (must hold TIMEOUT)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
i_req  input  1  core request valid
i_req_rw  input  1  0 = read, 1 = write
i_req_addr  input  ADDR_WIDTH  transfer address
i_req_wdata  input  DATA_WIDTH  write data
i_req_lock  input  1  keep bus locked after this transfer
o_req_ready  output  1  request accepted when i_req && o_req_ready
o_rsp_valid  output  1  one-cycle completion pulse
o_rsp_rdata  output  DATA_WIDTH  read data, valid with o_rsp_valid
o_rsp_err  output  1  timeout error, valid with o_rsp_valid
o_addr  output  ADDR_WIDTH  external address pins
o_rw  output  1  external rw pin (0 read, 1 write)
o_data  output  DATA_WIDTH  external data out
o_data_oe  output  1  data pin output enable
i_data  input  DATA_WIDTH  external data in
i_ready  input  1  external device ready
i_ext_lock  input  1  external agent holds bus lock
o_lock  output  1  this CPU holds bus lock
o_busy  output  1  state != IDLE or o_lock

Behaviour:
- Reset: asynchronous, active-low; clk is the only clock.
- Reset values: state IDLE; o_addr = 0, o_rw = 0, o_data = 0, o_data_oe = 0, o_lock = 0, o_rsp_valid = 0, o_rsp_err = 0, o_rsp_rdata = 0, o_busy = 0. o_req_ready = 1 if i_ext_lock = 0.
- Reset mid-transfer: aborts immediately; no response is issued.
- States: IDLE, ADDR, WAIT, DONE.
- o_req_ready = (state == IDLE) && (o_lock || !i_ext_lock).
- IDLE: on accept, latch rw, addr, wdata and lock into internal registers → ADDR.
- ADDR, 1 cycle: drive o_addr and o_rw; o_data = wdata and o_data_oe = 1 if write. Load wait counter = WAIT_STATES and clear timeout counter → WAIT. Set o_lock = 1 here if the latched lock = 1.
- WAIT: o_addr, o_rw and o_data/o_data_oe are held.
  - Wait counter decrements each cycle while nonzero.
  - Completion: counter == 0 && i_ready. Capture i_data (reads) → DONE with err = 0.
  - Otherwise the timeout counter increments. If TIMEOUT != 0 and the count reaches TIMEOUT → DONE with err = 1 and rdata = 0.
  - Completion in the same cycle as timeout: completion wins.
- DONE, 1 cycle: o_rsp_valid = 1; o_data_oe = 0 and o_rw = 0; o_addr holds → IDLE.
  - At the DONE→IDLE edge, o_lock is cleared if the latched lock = 0 or err = 1.
- Writes return o_rsp_rdata = 0.
- Latency with i_ready tied to 1: accept edge T; ADDR in cycle T+1; WAIT in cycles T+2 .. T+2+WAIT_STATES; o_rsp_valid in cycle T+3+WAIT_STATES.
- No request is accepted in ADDR, WAIT or DONE; back-to-back throughput is one transfer per 4 + WAIT_STATES cycles.
- Lock ownership:
  - While o_lock = 1, i_ext_lock is ignored.
  - While o_lock = 0 and i_ext_lock = 1, requests stall in IDLE.
  - i_ext_lock rising during a non-locked transfer does not abort it.
- Counters saturate and do not wrap.

Test Plan:
- WAIT_STATES = 1, i_ready = 1, read addr 0x1234 with i_data = 0xBEEF → o_addr = 0x1234 from cycle T+1; o_rsp_valid in cycle T+4 with rdata = 0xBEEF and err = 0.
- Write addr 0x00F0, data 0x5A5A → o_rw = 1 and o_data_oe = 1 in cycles T+1..T+3; both 0 in DONE; o_rsp_rdata = 0.
- i_ready held low 5 extra cycles, TIMEOUT = 255 → response delayed exactly 5 cycles, err = 0; then i_ready low forever → err = 1 with rdata = 0 after 255 WAIT cycles.
- i_ext_lock = 1 with an idle request pending → o_req_ready = 0 and no pin activity; i_ext_lock drops → accepted next cycle.
- Locked read followed by unlocked write, with i_ext_lock = 1 between them → o_lock = 1 from the first ADDR; second request still accepted; o_lock = 0 after the second DONE.
- n_rst asserted during WAIT → all outputs return to reset values asynchronously and o_rsp_valid never pulses.
